transpose_buf: RTL and testbench

- Parametrised N×N block transpose buffer with NBUF-deep block ring and per-block mode: transpose or pass-through.
- Accepts one row of N signed W-bit coefficients per cycle and emits one column (or row, in pass-through) per cycle.
- Sits between DCT passes in the JPEG encoder; replaces fixed 8×8/2-buffer dual-clock transposes where a single clock suffices.

---
 rtl/transpose_buf_if.sv | 35 +++
 rtl/transpose_buf.sv | 143 ++++++++++++++
 tb/tb_transpose_buf.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/transpose_buf_if.sv
// transpose_buf_if: row-in / vector-out stream bundle for transpose_buf.
// Handshake: a row on d transfers on the rising clk edge where d_valid is high
// and d_hold is low; an output vector on q transfers on the edge where q_valid
// is high and q_hold is low. While a transfer is stalled, the source keeps its
// payload and valid stable.
`timescale 1ns/1ps
interface transpose_buf_if #(
  parameter int N = 8,
  parameter int W = 13
);
  localparam int CW = $clog2(N);

  logic [N-1:0][W-1:0] d;
  logic [CW-1:0]       d_cnt;
  logic                d_mode;
  logic                d_valid;
  logic                d_hold;
  logic [N-1:0][W-1:0] q;
  logic [CW-1:0]       q_cnt;
  logic                q_mode;
  logic                q_valid;
  logic                q_hold;

  // Producer of rows / consumer of output vectors.
  modport master (
    output d, d_cnt, d_mode, d_valid, q_hold,
    input  d_hold, q, q_cnt, q_mode, q_valid
  );

  // The transpose buffer itself.
  modport slave (
    input  d, d_cnt, d_mode, d_valid, q_hold,
    output d_hold, q, q_cnt, q_mode, q_valid
  );
endinterface

// File: rtl/transpose_buf.sv
// transpose_buf: N x N block transpose buffer with an NBUF-deep block ring.
// Rows of N signed W-bit lanes are written one per cycle; each block is read
// back one vector per cycle, either as columns (transpose, mode=1) or as rows
// (pass-through, mode=0). The mode is captured with row 0 of each block.
// Optional build macro TRANSPOSE_SEQ_CHK_EN adds a sticky err output that flags
// any accepted row whose d_cnt disagrees with the internal row counter.
`timescale 1ns/1ps
module transpose_buf #(
  parameter int N    = 8,
  parameter int W    = 13,
  parameter int NBUF = 2
) (
  input  logic            clk,
  input  logic            reset,
  transpose_buf_if.slave  io
`ifdef TRANSPOSE_SEQ_CHK_EN
  ,
  output logic            err
`endif
);
  localparam int CW = $clog2(N);
  localparam int BI = $clog2(NBUF);   // buffer index width
  localparam int BW = BI + 1;         // block pointer width incl. wrap bit

  // Block storage, one packed row per entry; not reset.
  logic [N-1:0][W-1:0] mem [NBUF][N];
  logic [NBUF-1:0]     mode_r;

  logic [CW-1:0] wr_row;
  logic [BW-1:0] wr_blk;
  logic [CW-1:0] rd_col;
  logic [BW-1:0] rd_blk;

  logic [BI-1:0] wr_idx;
  logic [BI-1:0] rd_idx;
  logic [BW-1:0] occ;
  logic          full;
  logic          avail;
  logic          accept;
  logic          load;

  logic [N-1:0][W-1:0] rd_vec;
  logic [N-1:0][W-1:0] q_r;
  logic [CW-1:0]       q_cnt_r;
  logic                q_mode_r;
  logic                q_valid_r;

  assign wr_idx = wr_blk[BI-1:0];
  assign rd_idx = rd_blk[BI-1:0];

  // Pointers differ only in the wrap bit when the ring is full, so the
  // modular difference gives occupancy directly.
  assign occ    = wr_blk - rd_blk;
  assign full   = (occ == BW'(NBUF));
  assign avail  = (rd_blk != wr_blk);
  assign accept = io.d_valid & ~full;
  assign load   = avail & (~q_valid_r | ~io.q_hold);

  assign io.d_hold  = full;
  assign io.q       = q_r;
  assign io.q_cnt   = q_cnt_r;
  assign io.q_mode  = q_mode_r;
  assign io.q_valid = q_valid_r;

  // Row storage write: accepted row lands in the current write block.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_idx][wr_row] <= io.d;
    end
  end

  // Write-side counters and per-block mode capture on row 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_row <= '0;
      wr_blk <= '0;
      mode_r <= '0;
    end else if (accept) begin
      if (wr_row == '0) begin
        mode_r[wr_idx] <= io.d_mode;
      end
      if (wr_row == CW'(N - 1)) begin
        wr_row <= '0;
        wr_blk <= wr_blk + BW'(1);
      end else begin
        wr_row <= wr_row + CW'(1);
      end
    end
  end

  // Read mux: column rd_col across all rows, or row rd_col as stored.
  always_comb begin
    rd_vec = '0;
    for (int i = 0; i < N; i++) begin
      if (mode_r[rd_idx]) begin
        rd_vec[i] = mem[rd_idx][CW'(i)][rd_col];
      end else begin
        rd_vec[i] = mem[rd_idx][rd_col][i];
      end
    end
  end

  // Output register and read-side counters; the register holds while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r       <= '0;
      q_cnt_r   <= '0;
      q_mode_r  <= 1'b0;
      q_valid_r <= 1'b0;
      rd_col    <= '0;
      rd_blk    <= '0;
    end else if (load) begin
      q_r       <= rd_vec;
      q_cnt_r   <= rd_col;
      q_mode_r  <= mode_r[rd_idx];
      q_valid_r <= 1'b1;
      if (rd_col == CW'(N - 1)) begin
        rd_col <= '0;
        rd_blk <= rd_blk + BW'(1);
      end else begin
        rd_col <= rd_col + CW'(1);
      end
    end else if (!io.q_hold) begin
      q_valid_r <= 1'b0;
    end
  end

`ifdef TRANSPOSE_SEQ_CHK_EN
  // Sticky sequence error: the producer's row index disagrees with ours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (accept && (io.d_cnt != wr_row)) begin
      err <= 1'b1;
    end
  end
`else
  // d_cnt is informational only in this build.
  logic unused_d_cnt;
  assign unused_d_cnt = ^io.d_cnt;
`endif

endmodule

// File: tb/tb_transpose_buf.sv
// tb_transpose_buf: scoreboard bench for transpose_buf (N=8, W=13, NBUF=2).
// Build with TRANSPOSE_SEQ_CHK_EN defined to also exercise the err output.
`timescale 1ns/1ps
module tb_transpose_buf;
  localparam int N    = 8;
  localparam int W    = 13;
  localparam int NBUF = 2;
  localparam int CW   = $clog2(N);
  localparam int EW   = N * W + CW + 1;
  localparam int ROW_BUDGET = 2000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  transpose_buf_if #(.N(N), .W(W)) ifc ();

`ifdef TRANSPOSE_SEQ_CHK_EN
  logic err;
`endif

  transpose_buf #(.N(N), .W(W), .NBUF(NBUF)) dut (
    .clk   (clk),
    .reset (rst),
    .io    (ifc.slave)
`ifdef TRANSPOSE_SEQ_CHK_EN
    ,
    .err   (err)
`endif
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int acc_n    = 0;
  int hold_mode = 0;   // 0: never stall, 1: always stall, 2: random 30%

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Downstream stall generator.
  always @(posedge clk) begin
    #1;
    case (hold_mode)
      0:       ifc.q_hold = 1'b0;
      1:       ifc.q_hold = 1'b1;
      default: ifc.q_hold = ($urandom_range(0, 99) < 30);
    endcase
  end

  // Count rows that will be accepted at the coming edge.
  always @(negedge clk) begin
    if (!rst && ifc.d_valid && !ifc.d_hold) acc_n++;
  end

  // Output monitor: stability while stalled, and in-order compare on transfer.
  logic          prev_stall = 1'b0;
  logic [EW-1:0] prev_vec;
  always @(negedge clk) begin
    logic [EW-1:0] cur;
    logic [EW-1:0] e;
    cur = {ifc.q_mode, ifc.q_cnt, ifc.q};
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && ifc.q_valid) check("hold_stable", cur, prev_vec);
      prev_stall = ifc.q_valid && ifc.q_hold;
      prev_vec   = cur;
      if (ifc.q_valid && !ifc.q_hold) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_vec", cur, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 right after the row was accepted.
  task automatic drive_row(input logic [N-1:0][W-1:0] row, input logic [CW-1:0] cnt,
                           input logic mode);
    logic acc;
    acc = 1'b0;
    ifc.d       = row;
    ifc.d_cnt   = cnt;
    ifc.d_mode  = mode;
    ifc.d_valid = 1'b1;
    for (int k = 0; k < ROW_BUDGET; k++) begin
      @(negedge clk);
      acc = !ifc.d_hold;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) check("row_timeout", 0, 1);
  endtask

  // kind 0: d[i] = N*r + i; kind 1: random. bad_row >= 0 skews d_cnt from there on.
  task automatic send_block(input logic mode, input int kind, input int bad_row);
    logic [N-1:0][W-1:0] rows [N];
    logic [N-1:0][W-1:0] col;
    logic [CW-1:0]       cnt;
    for (int r = 0; r < N; r++)
      for (int i = 0; i < N; i++)
        rows[r][i] = (kind == 0) ? W'(N * r + i) : W'($urandom);
    for (int r = 0; r < N; r++) begin
      cnt = (bad_row >= 0 && r >= bad_row) ? CW'(r + 1) : CW'(r);
      drive_row(rows[r], cnt, mode);
`ifdef TRANSPOSE_SEQ_CHK_EN
      if (bad_row >= 0 && r == bad_row - 1) check("err_before", err, 0);
      if (bad_row >= 0 && r == bad_row)     check("err_set", err, 1);
`endif
    end
    ifc.d_valid = 1'b0;
    for (int c = 0; c < N; c++) begin
      for (int i = 0; i < N; i++) col[i] = mode ? rows[i][c] : rows[c][i];
      exp_q.push_back({mode, CW'(c), col});
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 1000; k++) begin
      if (exp_q.size() == 0 && !ifc.q_valid) break;
      @(negedge clk);
    end
    check("drain_empty", exp_q.size(), 0);
    step();
  endtask

  task automatic check_reset_outputs(input string phase);
    check({phase, "_q_valid"}, ifc.q_valid, 0);
    check({phase, "_q_cnt"},   ifc.q_cnt, 0);
    check({phase, "_q_mode"},  ifc.q_mode, 0);
    check({phase, "_q"},       ifc.q, 0);
    check({phase, "_d_hold"},  ifc.d_hold, 0);
`ifdef TRANSPOSE_SEQ_CHK_EN
    check({phase, "_err"},     err, 0);
`endif
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [N-1:0][W-1:0] row;
    logic prev_dh;
    logic seen;
    int   base;
    rst = 1'b1;
    ifc.d = '0;
    ifc.d_cnt = '0;
    ifc.d_mode = 1'b0;
    ifc.d_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    step();
    rst = 1'b0;
    step();

    // Transpose block with latency check.
    send_block(1'b1, 0, -1);
    @(negedge clk);
    check("lat_edge1_valid", ifc.q_valid, 0);
    @(negedge clk);
    check("lat_edge2_valid", ifc.q_valid, 1);
    check("lat_first_cnt", ifc.q_cnt, 0);
    wait_drain();

    // Pass-through block, same data.
    send_block(1'b0, 0, -1);
    wait_drain();

    // Full backpressure: three blocks into a two-deep ring.
    hold_mode = 1;
    step();
    base = acc_n;
    fork
      begin
        send_block(1'b1, 1, -1);
        send_block(1'b0, 1, -1);
        send_block(1'b1, 1, -1);
      end
    join_none
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ifc.d_hold) begin
        seen = 1'b1;
        break;
      end
    end
    check("full_seen", seen, 1);
    check("full_rows", acc_n - base, 2 * N);
    repeat (3) @(negedge clk);
    check("full_hold_kept", ifc.d_hold, 1);
    check("full_rows_kept", acc_n - base, 2 * N);
    hold_mode = 0;
    seen = 1'b0;
    prev_dh = ifc.d_hold;
    for (int k = 0; k < 200; k++) begin
      prev_dh = ifc.d_hold;
      @(negedge clk);
      if (ifc.q_valid && ifc.q_cnt == CW'(N - 1)) begin
        seen = 1'b1;
        break;
      end
    end
    check("blk0_last_seen", seen, 1);
    check("dhold_before_last", prev_dh, 1);
    check("dhold_after_last", ifc.d_hold, 0);
    wait fork;
    wait_drain();

    // Alternating modes under random downstream stalls.
    hold_mode = 2;
    send_block(1'b1, 1, -1);
    send_block(1'b0, 1, -1);
    send_block(1'b1, 1, -1);
    send_block(1'b0, 1, -1);
    hold_mode = 0;
    wait_drain();

    // Reset while block 0 is mid-output and block 1 is partially written.
    send_block(1'b1, 1, -1);
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < N; i++) row[i] = W'($urandom);
      drive_row(row, CW'(r), 1'b0);
    end
    check("mid_out_valid", ifc.q_valid, 1);
    rst = 1'b1;
    ifc.d_valid = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs("midrst");
    step();
    step();
    rst = 1'b0;
    step();
    send_block(1'b0, 1, -1);
    wait_drain();

`ifdef TRANSPOSE_SEQ_CHK_EN
    // Sequence error: d_cnt 0,1,2,4,... ; data path must be unaffected.
    send_block(1'b1, 0, 3);
    wait_drain();
    check("err_sticky", err, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
